// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, control width
// and the FSM state type.
package alu_pkg;

  localparam int CTR_W = 4;

  localparam logic [CTR_W-1:0] OP_AND   = 4'b0000;
  localparam logic [CTR_W-1:0] OP_OR    = 4'b0001;
  localparam logic [CTR_W-1:0] OP_ADD   = 4'b0010;
  localparam logic [CTR_W-1:0] OP_MULTU = 4'b0011;
  localparam logic [CTR_W-1:0] OP_DIVU  = 4'b0100;
  localparam logic [CTR_W-1:0] OP_SUB   = 4'b0110;
  localparam logic [CTR_W-1:0] OP_SLT   = 4'b0111;
  localparam logic [CTR_W-1:0] OP_NOR   = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one step per
// cycle, WIDTH steps per operation.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             busy_q;
  logic             mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic [WIDTH:0]   sum, shifted, diff;

  // Multiply: hi:lo holds partial product over the shrinking multiplier.
  // Divide: hi is the running remainder, lo shifts dividend out / quotient in.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, b_q};
    if (mode_q) begin
      if (!diff[WIDTH]) begin
        hi_d = diff[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = shifted[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // The final step's result is handed out combinationally so the caller can
  // register it on the same edge that completes the iteration.
  assign done = busy_q && (cnt_q == CNT_W'(WIDTH-1));
  assign hi   = hi_d;
  assign lo   = lo_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      cnt_q <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      hi_q   <= '0;
      lo_q   <= op_a;
      b_q    <= op_b;
      mode_q <= mode;
    end else if (busy_q) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered MIPS-style ALU with valid/ready handshake; single-cycle logic ops
// plus iterative MULTU/DIVU that stall the requester through in_ready.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int CTR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CTR_W-1:0] aluCtr,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluRes,
  output logic [WIDTH-1:0] aluResHi,
  output logic             zero,
  output logic             out_err
);

  import alu_pkg::*;

  state_t           state_q;
  logic [WIDTH-1:0] res_q, resh_q;
  logic             zero_q, err_q, divz_q;

  logic             accept, is_mul, is_div, sc_legal;
  logic [WIDTH-1:0] sc_res;
  logic             mdu_start, mdu_done;
  logic [WIDTH-1:0] mdu_hi, mdu_lo;

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (aluCtr == OP_MULTU);
  assign is_div    = (aluCtr == OP_DIVU);
  assign mdu_start = accept && (is_mul || is_div);

  always_comb begin
    sc_res   = '0;
    sc_legal = 1'b1;
    case (aluCtr)
      OP_AND:   sc_res = input1 & input2;
      OP_OR:    sc_res = input1 | input2;
      OP_ADD:   sc_res = input1 + input2;
      OP_SUB:   sc_res = input1 - input2;
      OP_SLT:   sc_res = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
      OP_NOR:   sc_res = ~(input1 | input2);
      OP_MULTU: sc_res = '0;
      OP_DIVU:  sc_res = '0;
      default:  sc_legal = 1'b0;
    endcase
  end

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk   (clk),
    .reset (reset),
    .start (mdu_start),
    .mode  (is_div),
    .op_a  (input1),
    .op_b  (input2),
    .done  (mdu_done),
    .hi    (mdu_hi),
    .lo    (mdu_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      resh_q  <= '0;
      zero_q  <= 1'b1;
      err_q   <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (is_mul) begin
              state_q <= ST_MUL;
            end else if (is_div) begin
              state_q <= ST_DIV;
              divz_q  <= (input2 == '0);
            end else begin
              state_q <= ST_DONE;
              res_q   <= sc_res;
              resh_q  <= '0;
              zero_q  <= (sc_res == '0);
              err_q   <= ~sc_legal;
            end
          end else if ((state_q == ST_DONE) && out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        ST_MUL, ST_DIV: begin
          if (mdu_done) begin
            state_q <= ST_DONE;
            res_q   <= mdu_lo;
            resh_q  <= mdu_hi;
            zero_q  <= (mdu_lo == '0);
            err_q   <= (state_q == ST_DIV) && divz_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign aluRes    = res_q;
  assign aluResHi  = resh_q;
  assign zero      = zero_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: single-cycle ops, MULTU/DIVU, illegal opcode,
// output back-pressure and reset during an iterative operation.
module tb_seq_alu;

  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010,
                         C_MUL = 4'b0011, C_DIV = 4'b0100, C_SUB = 4'b0110,
                         C_SLT = 4'b0111, C_NOR = 4'b1100, C_BAD = 4'b1111;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, zero, out_err;
  logic [3:0]  aluCtr;
  logic [31:0] input1, input2, aluRes, aluResHi;

  int checks = 0;
  int errors = 0;
  int lat;
  bit busy_ok, flag;

  seq_alu #(.WIDTH(32), .CTR_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluCtr    (aluCtr),
    .input1    (input1),
    .input2    (input2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .aluRes    (aluRes),
    .aluResHi  (aluResHi),
    .zero      (zero),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request, let it be accepted, scramble the inputs, then count
  // edges (accept edge = 1) until out_valid rises.
  task automatic issue(input string tag, input logic [3:0] ctr,
                       input logic [31:0] a, input logic [31:0] b,
                       output int l, output bit bok);
    aluCtr = ctr; input1 = a; input2 = b; in_valid = 1'b1;
    chk({tag, " in_ready"}, {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; aluCtr = C_BAD; input1 = 32'hDEAD_BEEF; input2 = 32'h0;
    l = 1; bok = 1'b1;
    while (!out_valid && l < 60) begin
      if (in_ready !== 1'b0) bok = 1'b0;
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic expect_out(input string tag, input int l, input int lexp,
                            input logic [31:0] lo, input logic [31:0] hi,
                            input logic z, input logic e);
    chk({tag, " latency"}, 64'(l), 64'(lexp));
    chk({tag, " out_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, " aluRes"}, {32'd0, aluRes}, {32'd0, lo});
    chk({tag, " aluResHi"}, {32'd0, aluResHi}, {32'd0, hi});
    chk({tag, " zero"}, {63'd0, zero}, {63'd0, z});
    chk({tag, " out_err"}, {63'd0, out_err}, {63'd0, e});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    aluCtr = 4'h0; input1 = 32'h0; input2 = 32'h0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset aluRes", {32'd0, aluRes}, 64'd0);
    chk("reset aluResHi", {32'd0, aluResHi}, 64'd0);
    chk("reset zero", {63'd0, zero}, 64'd1);
    chk("reset out_err", {63'd0, out_err}, 64'd0);
    reset = 1'b0;
    #1;
    chk("post-reset in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Single-cycle ops, back to back.
    issue("AND", C_AND, 32'h0000_00FF, 32'h0000_007F, lat, busy_ok);
    expect_out("AND", lat, 1, 32'h0000_007F, 32'h0, 1'b0, 1'b0);
    issue("OR", C_OR, 32'h0000_003F, 32'h0000_007F, lat, busy_ok);
    expect_out("OR", lat, 1, 32'h0000_007F, 32'h0, 1'b0, 1'b0);
    issue("ADD", C_ADD, 32'h0000_003F, 32'h0000_006F, lat, busy_ok);
    expect_out("ADD", lat, 1, 32'h0000_00AE, 32'h0, 1'b0, 1'b0);
    issue("SUB", C_SUB, 32'h0000_0078, 32'h0000_006F, lat, busy_ok);
    expect_out("SUB", lat, 1, 32'h0000_0009, 32'h0, 1'b0, 1'b0);
    issue("SLT", C_SLT, 32'h0000_0078, 32'h0000_006F, lat, busy_ok);
    expect_out("SLT", lat, 1, 32'h0, 32'h0, 1'b1, 1'b0);
    issue("NOR", C_NOR, 32'h0000_0078, 32'h0000_006F, lat, busy_ok);
    expect_out("NOR", lat, 1, 32'hFFFF_FF80, 32'h0, 1'b0, 1'b0);
    issue("SUB zero", C_SUB, 32'd5, 32'd5, lat, busy_ok);
    expect_out("SUB zero", lat, 1, 32'h0, 32'h0, 1'b1, 1'b0);
    issue("ADD wrap", C_ADD, 32'hFFFF_FFFF, 32'd1, lat, busy_ok);
    expect_out("ADD wrap", lat, 1, 32'h0, 32'h0, 1'b1, 1'b0);
    issue("SLT signed", C_SLT, 32'hFFFF_FFFF, 32'd1, lat, busy_ok);
    expect_out("SLT signed", lat, 1, 32'd1, 32'h0, 1'b0, 1'b0);

    // Iterative ops.
    issue("MULTU max", C_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busy_ok);
    expect_out("MULTU max", lat, 33, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
    chk("MULTU in_ready low while busy", {63'd0, busy_ok}, 64'd1);
    issue("DIVU 100/7", C_DIV, 32'd100, 32'd7, lat, busy_ok);
    expect_out("DIVU 100/7", lat, 33, 32'd14, 32'd2, 1'b0, 1'b0);
    chk("DIVU in_ready low while busy", {63'd0, busy_ok}, 64'd1);
    issue("DIVU by zero", C_DIV, 32'd9, 32'd0, lat, busy_ok);
    expect_out("DIVU by zero", lat, 33, 32'hFFFF_FFFF, 32'd9, 1'b0, 1'b1);
    issue("illegal op", C_BAD, 32'h1234_5678, 32'h0F0F_0F0F, lat, busy_ok);
    expect_out("illegal op", lat, 1, 32'h0, 32'h0, 1'b1, 1'b1);

    // Back-pressure: drain, then hold out_ready low after an ADD.
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue("ADD held", C_ADD, 32'd2, 32'd3, lat, busy_ok);
    expect_out("ADD held", lat, 1, 32'd5, 32'h0, 1'b0, 1'b0);
    aluCtr = C_ADD; input1 = 32'h10; input2 = 32'h0E; in_valid = 1'b1;
    flag = 1'b1;
    repeat (5) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || aluRes !== 32'd5 ||
          aluResHi !== 32'h0 || zero !== 1'b0 || out_err !== 1'b0) flag = 1'b0;
      @(posedge clk); #1;
    end
    chk("hold outputs stable", {63'd0, flag}, 64'd1);
    chk("hold aluRes", {32'd0, aluRes}, 64'd5);
    chk("hold in_ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    #1;
    chk("release in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("chained out_valid", {63'd0, out_valid}, 64'd1);
    chk("chained aluRes", {32'd0, aluRes}, 64'h1E);

    // Reset 10 cycles into a MULTU.
    aluCtr = C_MUL; input1 = 32'hFFFF_FFFF; input2 = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre-reset busy", {63'd0, out_valid}, 64'd0);
    reset = 1'b1;
    #1;
    chk("midop reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("midop reset aluRes", {32'd0, aluRes}, 64'd0);
    chk("midop reset aluResHi", {32'd0, aluResHi}, 64'd0);
    chk("midop reset zero", {63'd0, zero}, 64'd1);
    chk("midop reset out_err", {63'd0, out_err}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("after midop reset in_ready", {63'd0, in_ready}, 64'd1);
    flag = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) flag = 1'b0;
    end
    chk("discarded op never valid", {63'd0, flag}, 64'd1);
    issue("MULTU after reset", C_MUL, 32'd6, 32'd7, lat, busy_ok);
    expect_out("MULTU after reset", lat, 33, 32'd42, 32'h0, 1'b0, 1'b0);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
